debouncer: RTL and testbench



---
 rtl/debouncer.sv | 75 +++++++
 tb/tb_debouncer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Brief    : Two-flop synchronizer plus tick-sampled, symmetric per-bit
//            debounce for WIDTH independent raw inputs.
// Revision : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] signal_out
);

    localparam int c_TICK_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int c_CNT_W  = ($clog2(PULSE_CNT_MAX + 1) > 1) ? $clog2(PULSE_CNT_MAX + 1) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0]              sync1_q, sync1_d;
    logic [WIDTH-1:0]              sync2_q, sync2_d;
    logic [c_TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic                          tick;
    logic [WIDTH-1:0][c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]              out_q, out_d;

    always_comb begin
        sync1_d    = signal_in;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q == c_TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + c_TICK_W'(1);
    end

    // A sample that agrees with the output restarts the count: glitch rejection.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == c_CNT_LAST) begin
                    out_d[i] = ~out_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
        end
    end

    assign signal_out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debouncer
// Brief    : Directed self-checking bench for debouncer (W=2, S=4, P=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] signal_in = 2'b00;
    logic [1:0] signal_out;

    int vectors     = 0;
    int miscompares = 0;

    debouncer #(
        .WIDTH         (2),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .signal_in (signal_in),
        .signal_out(signal_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next n rising edges.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for a few edges, then release on a falling edge and apply v,
    // so the next rising edge is post-reset edge 1 and captures v.
    task automatic reset_and_apply(input logic [1:0] v);
        rst       = 1'b1;
        signal_in = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        signal_in = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: idle, reset state and free-running tick (tick seen at edges 4,8,..)
        reset_and_apply(2'b00);
        chk("reset_out", {30'd0, signal_out}, 32'd0);
        chk("reset_tick", {31'd0, dut.tick}, 32'd0);
        for (int k = 1; k <= 50; k++) begin
            step(1);
            chk("idle_tick", {31'd0, dut.tick}, ((k % 4) == 3) ? 32'd1 : 32'd0);
            chk("idle_out", {30'd0, signal_out}, 32'd0);
        end

        // 2: bit0 rises, captured at edge 1 -> output flips at edge 12
        reset_and_apply(2'b01);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk("rise_out", {30'd0, signal_out}, (k >= 12) ? 32'd1 : 32'd0);
        end

        // 3: short pulse (5 cycles) rejected, count returns to 0
        reset_and_apply(2'b01);
        step(4);
        chk("short_cnt_e4", {30'd0, dut.cnt_q[0]}, 32'd1);
        step(1);
        signal_in = 2'b00;
        step(3);
        chk("short_cnt_e8", {30'd0, dut.cnt_q[0]}, 32'd0);
        for (int k = 9; k <= 24; k++) begin
            step(1);
            chk("short_out", {30'd0, signal_out}, 32'd0);
        end

        // 4: fall debounce, then periodic 1-cycle glitches never re-raise
        reset_and_apply(2'b01);
        step(12);
        chk("fall_pre_high", {30'd0, signal_out}, 32'd1);
        signal_in = 2'b00;
        for (int k = 13; k <= 24; k++) begin
            step(1);
            chk("fall_out", {30'd0, signal_out}, (k >= 24) ? 32'd0 : 32'd1);
        end
        for (int g = 0; g < 6; g++) begin
            signal_in = 2'b01;
            step(1);
            chk("glitch_out", {30'd0, signal_out}, 32'd0);
            signal_in = 2'b00;
            for (int c = 0; c < 5; c++) begin
                step(1);
                chk("glitch_out", {30'd0, signal_out}, 32'd0);
            end
        end

        // 5: both bits rise together, then async reset clears output with no edge
        reset_and_apply(2'b11);
        step(11);
        chk("both_e11", {30'd0, signal_out}, 32'd0);
        step(1);
        chk("both_e12", {30'd0, signal_out}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_out", {30'd0, signal_out}, 32'd0);

        // 6: reset mid-count discards progress; full latency after release
        reset_and_apply(2'b01);
        step(7);
        chk("mid_cnt_e7", {30'd0, dut.cnt_q[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_cnt_async", {30'd0, dut.cnt_q[0]}, 32'd0);
        chk("mid_out_async", {30'd0, signal_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step(1);
            chk("post_rst_rise", {30'd0, signal_out}, (k >= 12) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
